// File: rtl/gtech_arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter: state encoding,
// requester count and hold-counter width.
package gtech_arb_pkg;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_TURN  = 2'b10
   } arb_state_e;

endpackage

// File: rtl/gtech_rr_pick.sv
// Rotating-priority picker: first set request scanning upward from ptr+1,
// wrapping modulo the requester count.
module gtech_rr_pick
   import gtech_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  win_oh_c_o,
   output logic [IDX_W-1:0] win_idx_c_o,
   output logic             any_c_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      found       = 1'b0;
      cand        = '0;
      win_idx_c_o = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = ptr_i + IDX_W'(k);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            win_idx_c_o = cand;
         end
      end
      any_c_o    = found;
      win_oh_c_o = found ? (NREQ'(1) << win_idx_c_o) : '0;
   end

endmodule

// File: rtl/gtech_rr_arb4.sv
// Four-requester round-robin arbiter with bounded tenure, one-cycle bus
// turnaround between tenures and a shared data path driven by the grantee.
module gtech_rr_arb4
   import gtech_arb_pkg::*;
#(
   parameter int unsigned W       = 8,
   parameter int unsigned MAXHOLD = 4
) (
   input  logic            CP,
   input  logic            CD,
   input  logic [NREQ-1:0] REQ,
   input  logic [W-1:0]    A0,
   input  logic [W-1:0]    A1,
   input  logic [W-1:0]    A2,
   input  logic [W-1:0]    A3,
   output logic [NREQ-1:0] GNT,
   output logic            VALID,
   output logic [W-1:0]    Z
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXHOLD - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             valid_q;

   logic [NREQ-1:0]  win_oh;
   logic [IDX_W-1:0] win_idx;
   logic             win_any;

   gtech_rr_pick u_pick (
      .req_i       (REQ),
      .ptr_i       (ptr_q),
      .win_oh_c_o  (win_oh),
      .win_idx_c_o (win_idx),
      .any_c_o     (win_any)
   );

   // Pointer resets to the last index so requester 0 wins the first scan
   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         state_q <= ST_IDLE;
         ptr_q   <= IDX_W'(NREQ - 1);
         cnt_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         valid_q <= |gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      case (state_q)
         ST_IDLE, ST_TURN: begin
            if (win_any) begin
               state_d = ST_GRANT;
               ptr_d   = win_idx;
               cnt_d   = '0;
               gnt_d   = win_oh;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // Counter tops out at MAXHOLD (<= 15), so it cannot wrap
            cnt_d = cnt_q + CNT_W'(1);
            if (!REQ[ptr_q] || (cnt_q == CNT_LAST)) begin
               state_d = ST_TURN;
            end else begin
               gnt_d = gnt_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   logic [W-1:0] a_arr [NREQ];
   logic [W-1:0] z_c;

   assign a_arr[0] = A0;
   assign a_arr[1] = A1;
   assign a_arr[2] = A2;
   assign a_arr[3] = A3;

   // AND-OR mux follows the grant flops, so reset clears it without a clock
   always_comb begin
      z_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         z_c = z_c | (a_arr[i] & {W{gnt_q[i]}});
      end
   end

   assign GNT   = gnt_q;
   assign VALID = valid_q;
   assign Z     = z_c;

endmodule

// File: tb/tb_gtech_rr_arb4.sv
// Randomised and directed bench for gtech_rr_arb4 against a tenure-level
// reference model; runs a MAXHOLD=4 and a MAXHOLD=1 instance side by side.
module tb_gtech_rr_arb4;

   localparam int W = 8;

   logic         cp = 1'b0;
   logic         cd;
   logic [3:0]   req;
   logic [W-1:0] a0, a1, a2, a3;
   logic [3:0]   gnt4, gnt1;
   logic         v4, v1;
   logic [W-1:0] z4, z1;

   int checks = 0;
   int errors = 0;

   // Model state per instance: current owner (-1 none), cycles held, last winner
   int owner [2];
   int held  [2];
   int last  [2];
   int maxh  [2];

   gtech_rr_arb4 #(.W(W), .MAXHOLD(4)) u_dut4 (
      .CP(cp), .CD(cd), .REQ(req), .A0(a0), .A1(a1), .A2(a2), .A3(a3),
      .GNT(gnt4), .VALID(v4), .Z(z4)
   );

   gtech_rr_arb4 #(.W(W), .MAXHOLD(1)) u_dut1 (
      .CP(cp), .CD(cd), .REQ(req), .A0(a0), .A1(a1), .A2(a2), .A3(a3),
      .GNT(gnt1), .VALID(v1), .Z(z1)
   );

   always #5 cp = ~cp;

   function automatic void mdl_reset();
      for (int d = 0; d < 2; d++) begin
         owner[d] = -1;
         held[d]  = 0;
         last[d]  = 3;
      end
   endfunction

   // A tenure ends when its owner drops or has held for maxh cycles; the cycle
   // after that is a dead turnaround, after which a fresh scan takes place.
   function automatic void mdl_edge(logic [3:0] r);
      for (int d = 0; d < 2; d++) begin
         if (owner[d] >= 0) begin
            if (!r[owner[d]] || held[d] >= maxh[d]) owner[d] = -1;
            else held[d] = held[d] + 1;
         end else if (r != 4'b0000) begin
            bit found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               int j = (last[d] + k) % 4;
               if (!found && r[j]) begin
                  found    = 1'b1;
                  owner[d] = j;
                  last[d]  = j;
                  held[d]  = 1;
               end
            end
         end
      end
   endfunction

   function automatic logic [3:0] exp_gnt(int d);
      logic [3:0] one = 4'b0001;
      return (owner[d] >= 0) ? (one << owner[d]) : 4'b0000;
   endfunction

   function automatic logic [W-1:0] exp_z(int d);
      case (owner[d])
         0:       return a0;
         1:       return a1;
         2:       return a2;
         3:       return a3;
         default: return '0;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cmp_all();
      check("gnt4",  32'(gnt4), 32'(exp_gnt(0)));
      check("valid4", 32'(v4),  32'(owner[0] >= 0));
      check("z4",    32'(z4),   32'(exp_z(0)));
      check("gnt1",  32'(gnt1), 32'(exp_gnt(1)));
      check("valid1", 32'(v1),  32'(owner[1] >= 0));
      check("z1",    32'(z1),   32'(exp_z(1)));
      check("onehot4", 32'($countones(gnt4) <= 1), 32'(1));
      check("onehot1", 32'($countones(gnt1) <= 1), 32'(1));
   endtask

   task automatic step();
      logic [3:0] r;
      r = req;
      @(posedge cp);
      mdl_edge(r);
      #1;
      cmp_all();
   endtask

   task automatic do_reset();
      cd = 1'b0;
      #1;
      mdl_reset();
      check("rst_gnt4", 32'(gnt4), 32'(0));
      check("rst_valid4", 32'(v4), 32'(0));
      check("rst_z4", 32'(z4), 32'(0));
      repeat (2) @(posedge cp);
      @(negedge cp);
      cd = 1'b1;
   endtask

   initial begin
      maxh[0] = 4;
      maxh[1] = 1;
      cd  = 1'b0;
      req = 4'b0000;
      a0 = 8'hA5; a1 = 8'h3C; a2 = 8'h5A; a3 = 8'hC3;
      mdl_reset();

      // Single steady requester: 4 granted, 1 turnaround, repeat
      do_reset();
      req = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         step();
         check("seq27_gnt4", 32'(gnt4), 32'((i % 5 == 4) ? 4'b0000 : 4'b0001));
         check("seq27_z4",   32'(z4),   32'((i % 5 == 4) ? 8'h00 : 8'hA5));
         check("seq27_gnt1", 32'(gnt1), 32'((i % 2 == 1) ? 4'b0000 : 4'b0001));
      end

      // All requesting: rotation 0,1,2,3,0 with a 20-cycle period
      req = 4'b0000;
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 21; i++) begin
         logic [3:0] one;
         one = 4'b0001;
         step();
         check("seq28_gnt4", 32'(gnt4),
               32'((i % 5 == 4) ? 4'b0000 : (one << ((i / 5) % 4))));
      end

      // Data path across a 0 -> 1 handover, then idle with busy A inputs
      req = 4'b0000;
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         step();
         check("seq32_z4", 32'(z4), 32'((i < 4) ? 8'hA5 : (i == 4) ? 8'h00 : 8'h3C));
      end
      req = 4'b0000;
      step();
      step();
      a0 = 8'hFF; a1 = 8'hFF; a2 = 8'hFF; a3 = 8'hFF;
      step();
      check("idle_z4", 32'(z4), 32'(0));
      check("idle_gnt4", 32'(gnt4), 32'(0));

      // Owner releases early: turnaround, then 3, then wrap to 0
      a0 = 8'hA5; a1 = 8'h3C; a2 = 8'h5A; a3 = 8'hC3;
      do_reset();
      req = 4'b0100;
      step();
      check("seq29_g2", 32'(gnt4), 32'(4'b0100));
      step();
      req = 4'b1011;
      step();
      check("seq29_turn", 32'(gnt4), 32'(4'b0000));
      step();
      check("seq29_g3", 32'(gnt4), 32'(4'b1000));
      check("seq29_z3", 32'(z4), 32'(8'hC3));
      repeat (3) step();
      check("seq29_g3_held", 32'(gnt4), 32'(4'b1000));
      step();
      check("seq29_turn2", 32'(gnt4), 32'(4'b0000));
      step();
      check("seq29_g0", 32'(gnt4), 32'(4'b0001));

      // Asynchronous reset in the middle of a tenure
      req = 4'b0000;
      do_reset();
      req = 4'b0100;
      step();
      step();
      check("seq30_pre", 32'(gnt4), 32'(4'b0100));
      #2;
      cd = 1'b0;
      #1;
      check("seq30_gnt", 32'(gnt4), 32'(0));
      check("seq30_valid", 32'(v4), 32'(0));
      check("seq30_z", 32'(z4), 32'(0));
      mdl_reset();
      req = 4'b1111;
      @(negedge cp);
      cd = 1'b1;
      step();
      check("seq30_first", 32'(gnt4), 32'(4'b0001));

      // Single-cycle tenures alternate between two requesters
      req = 4'b0000;
      do_reset();
      req = 4'b0110;
      step(); check("seq31_a", 32'(gnt1), 32'(4'b0010));
      step(); check("seq31_b", 32'(gnt1), 32'(4'b0000));
      step(); check("seq31_c", 32'(gnt1), 32'(4'b0100));
      step(); check("seq31_d", 32'(gnt1), 32'(4'b0000));

      // Randomised traffic with sticky requests so tenures run to completion
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         a0 = 8'($urandom); a1 = 8'($urandom);
         a2 = 8'($urandom); a3 = 8'($urandom);
         if (i == 700) begin
            do_reset();
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
